// File: rtl/motor_pkg.sv
// Shared encodings for the miniCar H-bridge driver: command directions, channel FSM states
// and the IN1/IN2 pin patterns driven onto the bridge.
package motor_pkg;

  typedef enum logic [1:0] {
    DIR_COAST = 2'b00,
    DIR_FWD   = 2'b01,
    DIR_REV   = 2'b10,
    DIR_BRAKE = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DECEL,
    ST_DEAD,
    ST_BRAKE
  } state_e;

  localparam logic [1:0] IN_FWD = 2'b10;
  localparam logic [1:0] IN_REV = 2'b01;
  localparam logic [1:0] IN_BRK = 2'b11;
  localparam logic [1:0] IN_OFF = 2'b00;

  function automatic logic is_drive(input dir_e d);
    return (d == DIR_FWD) || (d == DIR_REV);
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: target register, ramp/dead-time FSM, glitch-free PWM compare and
// IN-pin decode. Pulls its timing from the shared PWM counter and ramp tick in the top.
module motor_channel
  import motor_pkg::*;
#(
  parameter  int PWM_PERIOD  = 100,
  parameter  int DEAD_CYCLES = 500,
  localparam int PCW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           estop,
  input  logic           ramp_tick,
  input  logic           wrap,
  input  logic [PCW-1:0] pcnt,
  input  logic           cmd_we,
  input  dir_e           cmd_dir,
  input  logic [PCW-1:0] cmd_duty,
  output logic [1:0]     in_pins,
  output logic           pwm,
  output logic           busy
);
  localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  state_e         state_q, state_d;
  dir_e           tgt_dir_q, cur_dir_q, cur_dir_d;
  logic [PCW-1:0] tgt_duty_q, cur_duty_q, cur_duty_d, cmp_q;
  logic [DCW-1:0] dead_q, dead_d;
  logic           pwm_q, tgt_drive, run_like_d, force_d;

  assign tgt_drive = is_drive(tgt_dir_q) && (tgt_duty_q != '0);

  // NOTE: sequential state is only ever assigned with <= so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tgt_dir_q  <= DIR_COAST;
      tgt_duty_q <= '0;
    end else if (estop) begin
      tgt_dir_q  <= DIR_COAST;
      tgt_duty_q <= '0;
    end else if (cmd_we) begin
      tgt_dir_q  <= cmd_dir;
      tgt_duty_q <= cmd_duty;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_dir_d  = cur_dir_q;
    cur_duty_d = cur_duty_q;
    dead_d     = '0;
    case (state_q)
      ST_IDLE: begin
        cur_duty_d = '0;
        if (tgt_drive) begin
          state_d   = ST_RUN;
          cur_dir_d = tgt_dir_q;
        end else if (tgt_dir_q == DIR_BRAKE) begin
          state_d = ST_BRAKE;
        end
      end
      ST_RUN: begin
        if (!tgt_drive || (tgt_dir_q != cur_dir_q)) begin
          state_d = ST_DECEL;
        end else if (ramp_tick) begin
          if (cur_duty_q < tgt_duty_q)      cur_duty_d = cur_duty_q + 1'b1;
          else if (cur_duty_q > tgt_duty_q) cur_duty_d = cur_duty_q - 1'b1;
        end
      end
      ST_DECEL: begin
        if (tgt_drive && (tgt_dir_q == cur_dir_q)) begin
          state_d = ST_RUN;
        end else if (cur_duty_q == '0) begin
          if (tgt_drive)                    state_d = ST_DEAD;
          else if (tgt_dir_q == DIR_BRAKE)  state_d = ST_BRAKE;
          else                              state_d = ST_IDLE;
        end else if (ramp_tick) begin
          cur_duty_d = cur_duty_q - 1'b1;
        end
      end
      ST_DEAD: begin
        cur_duty_d = '0;
        if (dead_q == DCW'(DEAD_CYCLES - 1)) begin
          if (tgt_drive) begin
            state_d   = ST_RUN;
            cur_dir_d = tgt_dir_q;
          end else if (tgt_dir_q == DIR_BRAKE) begin
            state_d = ST_BRAKE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          dead_d = dead_q + 1'b1;
        end
      end
      ST_BRAKE: begin
        cur_duty_d = '0;
        // Leaving brake for a driven direction always passes through a full dead time.
        if (tgt_drive)                    state_d = ST_DEAD;
        else if (tgt_dir_q != DIR_BRAKE)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (estop) begin
      state_d    = ST_BRAKE;
      cur_duty_d = '0;
      dead_d     = '0;
    end
  end

  assign run_like_d = (state_d == ST_RUN) || (state_d == ST_DECEL);
  assign force_d    = (state_d == ST_DEAD) || (state_d == ST_BRAKE);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_dir_q  <= DIR_COAST;
      cur_duty_q <= '0;
      dead_q     <= '0;
      cmp_q      <= '0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_dir_q  <= cur_dir_d;
      cur_duty_q <= cur_duty_d;
      dead_q     <= dead_d;
      // Compare value only moves at the period boundary so no partial pulses appear.
      cmp_q      <= !run_like_d ? '0 : (wrap ? cur_duty_d : cmp_q);
      pwm_q      <= force_d || (run_like_d && (pcnt < cmp_q));
    end
  end

  always_comb begin
    in_pins = IN_OFF;
    case (state_q)
      ST_RUN, ST_DECEL:  in_pins = (cur_dir_q == DIR_FWD) ? IN_FWD : IN_REV;
      ST_DEAD, ST_BRAKE: in_pins = IN_BRK;
      default:           in_pins = IN_OFF;
    endcase
  end

  assign pwm  = pwm_q;
  assign busy = !((state_q == ST_IDLE) || (state_q == ST_BRAKE)) &&
                !((state_q == ST_RUN) && (cur_duty_q == tgt_duty_q));

endmodule

// File: rtl/motor_drive_ramp.sv
// N_CH-channel L298N driver: shared PWM counter and ramp prescaler, command decode and
// estop fan-out feeding one motor_channel per bridge, with output packing.
module motor_drive_ramp
  import motor_pkg::*;
#(
  parameter  int N_CH        = 2,
  parameter  int PWM_PERIOD  = 100,
  parameter  int RAMP_DIV    = 1000,
  parameter  int DEAD_CYCLES = 500,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              estop,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [1:0]        cmd_dir,
  input  logic [7:0]        cmd_duty,
  output logic [2*N_CH-1:0] DCDriver_IN,
  output logic [N_CH-1:0]   PWM,
  output logic [N_CH-1:0]   busy
);
  localparam int PCW = $clog2(PWM_PERIOD + 1);
  localparam int PRW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [PCW-1:0] pcnt_q, duty_sat;
  logic [PRW-1:0] pre_q;
  logic           rdy_q, wrap, ramp_tick, accept;

  assign wrap      = (pcnt_q == PCW'(PWM_PERIOD - 1));
  assign ramp_tick = (pre_q == PRW'(RAMP_DIV - 1));
  assign cmd_ready = rdy_q && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign duty_sat  = (int'(cmd_duty) > PWM_PERIOD) ? PCW'(PWM_PERIOD) : PCW'(cmd_duty);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      pre_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      pcnt_q <= wrap ? '0 : pcnt_q + 1'b1;
      pre_q  <= ramp_tick ? '0 : pre_q + 1'b1;
      rdy_q  <= 1'b1;
    end
  end

  // Out-of-range channel numbers match no instance, so they are accepted and dropped.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    motor_channel #(
      .PWM_PERIOD (PWM_PERIOD),
      .DEAD_CYCLES(DEAD_CYCLES)
    ) u_ch (
      .clk_in   (clk_in),
      .rst      (rst),
      .estop    (estop),
      .ramp_tick(ramp_tick),
      .wrap     (wrap),
      .pcnt     (pcnt_q),
      .cmd_we   (accept && (int'(cmd_ch) == k)),
      .cmd_dir  (dir_e'(cmd_dir)),
      .cmd_duty (duty_sat),
      .in_pins  (DCDriver_IN[2*k +: 2]),
      .pwm      (PWM[k]),
      .busy     (busy[k])
    );
  end

endmodule

// File: tb/tb_motor_drive_ramp.sv
// Self-checking bench for motor_drive_ramp: directed ramp/reversal/estop/reset sequences,
// a table of settled-state vectors and a randomized last-command-wins reference model.
module tb_motor_drive_ramp;
  localparam int N_CH = 2;
  localparam int PP   = 10;
  localparam int RD   = 4;
  localparam int DC   = 8;

  logic       clk_in = 1'b0;
  logic       rst, estop, cmd_valid, cmd_ready;
  logic       cmd_ch;
  logic [1:0] cmd_dir;
  logic [7:0] cmd_duty;
  logic [3:0] dcdriver_in;
  logic [1:0] pwm, busy;

  int n_cmp = 0;
  int n_bad = 0;

  motor_drive_ramp #(
    .N_CH(N_CH), .PWM_PERIOD(PP), .RAMP_DIV(RD), .DEAD_CYCLES(DC)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .estop      (estop),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_dir    (cmd_dir),
    .cmd_duty   (cmd_duty),
    .DCDriver_IN(dcdriver_in),
    .PWM        (pwm),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int ch, input logic [1:0] dir, input logic [7:0] duty);
    cmd_ch    = 1'(ch);
    cmd_dir   = dir;
    cmd_duty  = duty;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic pwm_count(input int ch, output int cnt);
    cnt = 0;
    for (int i = 0; i < PP; i++) begin
      step();
      cnt += int'(pwm[ch]);
    end
  endtask

  // Settled behaviour derived from the command alone.
  function automatic logic [1:0] exp_pins(input logic [1:0] dir, input logic [7:0] duty);
    if (dir == 2'b11) return 2'b11;
    if (duty == 8'd0) return 2'b00;
    if (dir == 2'b01) return 2'b10;
    if (dir == 2'b10) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int exp_on(input logic [1:0] dir, input logic [7:0] duty);
    if (dir == 2'b11) return PP;
    if ((dir == 2'b01 || dir == 2'b10) && duty != 8'd0) return (int'(duty) > PP) ? PP : int'(duty);
    return 0;
  endfunction

  // Any entry into a driven pattern must come from off, or from a full dead time of brake.
  logic [1:0] mon_prev[N_CH] = '{default: 2'b00};
  int         mon_run[N_CH]  = '{default: 0};
  always @(negedge clk_in) begin
    logic [1:0] cur;
    for (int k = 0; k < N_CH; k++) begin
      cur = dcdriver_in[2*k +: 2];
      if (cur != mon_prev[k]) begin
        if (cur == 2'b10 || cur == 2'b01)
          check($sformatf("dead_gap_ch%0d", k),
                32'((mon_prev[k] == 2'b00) || (mon_prev[k] == 2'b11 && mon_run[k] >= DC)), 32'd1);
        mon_run[k] = 0;
      end
      if (cur == 2'b11) mon_run[k]++;
      mon_prev[k] = cur;
    end
  end

  typedef struct {
    int         ch;
    logic [1:0] dir;
    logic [7:0] duty;
    logic [1:0] exp_in;
    int         exp_on;
  } vec_t;

  vec_t       vecs[8];
  logic [1:0] m_dir[N_CH];
  logic [7:0] m_duty[N_CH];

  initial begin
    int n, on, c, ncmd, ch;
    logic [1:0] d;
    logic [7:0] du;

    vecs[0] = '{0, 2'b01, 8'd200, 2'b10, 10};
    vecs[1] = '{0, 2'b01, 8'd0,   2'b00, 0};
    vecs[2] = '{1, 2'b11, 8'd0,   2'b11, 10};
    vecs[3] = '{1, 2'b10, 8'd3,   2'b01, 3};
    vecs[4] = '{0, 2'b10, 8'd7,   2'b01, 7};
    vecs[5] = '{1, 2'b00, 8'd9,   2'b00, 0};
    vecs[6] = '{0, 2'b11, 8'd4,   2'b11, 10};
    vecs[7] = '{0, 2'b01, 8'd10,  2'b10, 10};

    rst = 1'b1; estop = 1'b0; cmd_valid = 1'b0; cmd_ch = 1'b0; cmd_dir = 2'b00; cmd_duty = 8'd0;
    step(3);
    check("rst_pins", 32'(dcdriver_in), 32'd0);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    #1;
    check("ready_before_clk", 32'(cmd_ready), 32'd0);
    step();
    check("ready_after_clk", 32'(cmd_ready), 32'd1);
    on = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      on += int'(pwm != 2'b00) + int'(dcdriver_in != 4'b0000);
    end
    check("idle_quiet", 32'(on), 32'd0);

    // Forward ramp to 5 on ch0.
    send(0, 2'b01, 8'd5);
    step();
    check("fwd_pins", 32'(dcdriver_in[1:0]), 32'b10);
    check("fwd_busy", 32'(busy[0]), 32'd1);
    n = 1;
    while (busy[0] && n < 40) begin step(); n++; end
    check("ramp_up_time_ok", 32'(n >= 16 && n <= 24), 32'd1);
    check("ch1_pins_untouched", 32'(dcdriver_in[3:2]), 32'd0);
    check("ch1_busy_untouched", 32'(busy[1]), 32'd0);
    step(PP);
    pwm_count(0, on);
    check("fwd5_on", 32'(on), 32'd5);

    // Reversal through dead time.
    send(0, 2'b10, 8'd5);
    n = 0;
    while (dcdriver_in[1:0] == 2'b10 && n < 60) begin step(); n++; end
    check("decel_time_ok", 32'(n >= 17 && n <= 24), 32'd1);
    check("rev_enters_brk", 32'(dcdriver_in[1:0]), 32'b11);
    n = 0;
    while (dcdriver_in[1:0] == 2'b11 && n < 30) begin step(); n++; end
    check("dead_len", 32'(n), 32'(DC));
    check("rev_pins", 32'(dcdriver_in[1:0]), 32'b01);
    n = 0;
    while (busy[0] && n < 40) begin step(); n++; end
    check("rev_settled", 32'(busy[0]), 32'd0);
    step(PP);
    pwm_count(0, on);
    check("rev5_on", 32'(on), 32'd5);

    // Settled-state vectors.
    for (int i = 0; i < 8; i++) begin
      c = vecs[i].ch;
      send(c, vecs[i].dir, vecs[i].duty);
      step(150);
      check($sformatf("vec%0d_pins", i), 32'(dcdriver_in[2*c +: 2]), 32'(vecs[i].exp_in));
      check($sformatf("vec%0d_busy", i), 32'(busy[c]), 32'd0);
      pwm_count(c, on);
      check($sformatf("vec%0d_on", i), 32'(on), 32'(vecs[i].exp_on));
    end

    // Emergency stop while both channels ramp.
    send(0, 2'b01, 8'd8);
    send(1, 2'b10, 8'd6);
    step(6);
    estop = 1'b1;
    #1;
    check("estop_ready_low", 32'(cmd_ready), 32'd0);
    step();
    check("estop_pins", 32'(dcdriver_in), 32'hF);
    check("estop_pwm", 32'(pwm), 32'h3);
    check("estop_busy", 32'(busy), 32'd0);
    send(0, 2'b01, 8'd5);
    step(3);
    check("estop_holds", 32'(dcdriver_in), 32'hF);
    estop = 1'b0;
    #1;
    check("release_ready", 32'(cmd_ready), 32'd1);
    step();
    check("release_pins", 32'(dcdriver_in), 32'd0);
    check("release_pwm", 32'(pwm), 32'd0);
    step(60);
    check("estop_cmd_dropped", 32'(dcdriver_in), 32'd0);

    // Asynchronous reset in the middle of a dead time.
    send(0, 2'b01, 8'd3);
    step(40);
    send(0, 2'b10, 8'd3);
    n = 0;
    while (dcdriver_in[1:0] != 2'b11 && n < 60) begin step(); n++; end
    check("reached_dead", 32'(dcdriver_in[1:0]), 32'b11);
    step(2);
    #3 rst = 1'b1;
    #1;
    check("async_rst_pins", 32'(dcdriver_in), 32'd0);
    check("async_rst_pwm", 32'(pwm), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_ready", 32'(cmd_ready), 32'd0);
    step(2);
    @(negedge clk_in);
    rst = 1'b0;
    step();
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    step(40);
    check("post_rst_idle", 32'(dcdriver_in), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Randomized commands against the last-command-wins model. With two channels every
    // cmd_ch code names a real channel.
    for (int k = 0; k < N_CH; k++) begin m_dir[k] = 2'b00; m_duty[k] = 8'd0; end
    for (int it = 0; it < 24; it++) begin
      ncmd = $urandom_range(1, 3);
      for (int j = 0; j < ncmd; j++) begin
        ch = $urandom_range(0, N_CH - 1);
        d  = 2'($urandom_range(0, 3));
        du = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
        send(ch, d, du);
        m_dir[ch]  = d;
        m_duty[ch] = du;
        step($urandom_range(0, 30));
      end
      step(150);
      for (int k = 0; k < N_CH; k++) begin
        check($sformatf("rnd%0d_ch%0d_pins", it, k), 32'(dcdriver_in[2*k +: 2]),
              32'(exp_pins(m_dir[k], m_duty[k])));
        check($sformatf("rnd%0d_ch%0d_busy", it, k), 32'(busy[k]), 32'd0);
        pwm_count(k, on);
        check($sformatf("rnd%0d_ch%0d_on", it, k), 32'(on), 32'(exp_on(m_dir[k], m_duty[k])));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
